// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl
//   Drives a dual-read/single-write RAM as a two-line circular buffer so that a
//   raster pixel stream comes out as vertical 3-pixel columns (rows r, r-1, r-2)
//   for a 3x3 Sobel window, with the column/row position and window flags.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   valid_i / ready_o / pix_i    input pixel stream (raster order)
//   valid_o / ready_i            output column handshake (one register stage)
//   pix_o, line1_o, line2_o      pixel at rows r, r-1, r-2 of the same column
//   col_o, row_o                 position of pix_o
//   win_valid_o                  line1_o/line2_o carry real data (row_o >= 2)
//   eol_o, eof_o                 pix_o is last of line / last of frame
//   ram_*                        RAM write port, two read ports (1-cycle read latency)
module line_buffer_ctrl #(
    parameter int WIDTH_P = 8,
    parameter int IMG_W_P = 640,
    parameter int IMG_H_P = 480
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [WIDTH_P-1:0]            pix_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [WIDTH_P-1:0]            pix_o,
    output logic [WIDTH_P-1:0]            line1_o,
    output logic [WIDTH_P-1:0]            line2_o,
    output logic [$clog2(IMG_W_P)-1:0]    col_o,
    output logic [$clog2(IMG_H_P)-1:0]    row_o,
    output logic                          win_valid_o,
    output logic                          eol_o,
    output logic                          eof_o,
    output logic [WIDTH_P-1:0]            ram_data_o,
    output logic [$clog2(2*IMG_W_P)-1:0]  ram_wr_addr_o,
    output logic [$clog2(2*IMG_W_P)-1:0]  ram_rd_addr_a_o,
    output logic [$clog2(2*IMG_W_P)-1:0]  ram_rd_addr_b_o,
    output logic                          ram_wr_en_o,
    output logic                          ram_rd_en_a_o,
    output logic                          ram_rd_en_b_o,
    input  logic [WIDTH_P-1:0]            ram_data_a_i,
    input  logic [WIDTH_P-1:0]            ram_data_b_i
);

    localparam int CW = $clog2(IMG_W_P);
    localparam int RW = $clog2(IMG_H_P);
    localparam int AW = $clog2(2*IMG_W_P);

    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W_P-1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H_P-1);
    localparam logic [AW-1:0] SLOT1_BASE = AW'(IMG_W_P);

    typedef enum logic [1:0] {FILL0, FILL1, RUN} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic            r_ptr;

    logic            r_valid;
    logic [WIDTH_P-1:0] r_pix;
    logic [CW-1:0]   r_col_o;
    logic [RW-1:0]   r_row_o;
    logic            r_win;
    logic            r_eol;
    logic            r_eof;

    logic            w_accept;
    logic            w_col_last;
    logic            w_row_last;
    logic [AW-1:0]   w_base_old;
    logic [AW-1:0]   w_base_prev;

    assign ready_o    = !r_valid | ready_i;
    // Gated by reset so a pixel offered during reset never touches the RAM.
    assign w_accept   = valid_i & ready_o & ~rst_i;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);

    // Slot r_ptr holds row r-2 and is overwritten by row r; the RAM returns the
    // old word on a same-address read/write, so port B still sees row r-2.
    assign w_base_old  = r_ptr ? SLOT1_BASE : '0;
    assign w_base_prev = r_ptr ? '0 : SLOT1_BASE;

    assign ram_data_o      = pix_i;
    assign ram_wr_addr_o   = w_base_old + AW'(r_col);
    assign ram_rd_addr_b_o = w_base_old + AW'(r_col);
    assign ram_rd_addr_a_o = w_base_prev + AW'(r_col);
    assign ram_wr_en_o     = w_accept;
    assign ram_rd_en_a_o   = w_accept;
    assign ram_rd_en_b_o   = w_accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= FILL0;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept && w_col_last) begin
            case (r_state)
                FILL0:   w_state_nxt = FILL1;
                FILL1:   w_state_nxt = RUN;
                RUN:     w_state_nxt = w_row_last ? FILL0 : RUN;
                default: w_state_nxt = FILL0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_col <= '0;
            r_row <= '0;
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_ptr <= ~r_ptr;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_pix   <= '0;
            r_col_o <= '0;
            r_row_o <= '0;
            r_win   <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_pix   <= pix_i;
            r_col_o <= r_col;
            r_row_o <= r_row;
            r_win   <= (r_state == RUN);
            r_eol   <= w_col_last;
            r_eof   <= w_col_last & w_row_last;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o     = r_valid;
    assign pix_o       = r_pix;
    assign col_o       = r_col_o;
    assign row_o       = r_row_o;
    assign win_valid_o = r_win;
    assign eol_o       = r_eol;
    assign eof_o       = r_eof;

    // RAM read data arrives in the same cycle as the registered stage; rows that
    // do not exist yet are forced to zero instead of exposing stale RAM words.
    assign line1_o = (r_row_o == '0)        ? '0 : ram_data_a_i;
    assign line2_o = (r_row_o < RW'(2))     ? '0 : ram_data_b_i;

endmodule
